// File: rtl/uart_regs_pkg.sv
// Shared definitions for the UART APB register block: register indexes,
// STATUS/CONF bit positions, reset constants and address-decode helpers.
package uart_regs_pkg;

    typedef enum logic [3:0] {
        IDX_TX       = 4'd0,
        IDX_RX       = 4'd1,
        IDX_BAUD     = 4'd2,
        IDX_CONF     = 4'd3,
        IDX_RXTRIG   = 4'd4,
        IDX_TXTRIG   = 4'd5,
        IDX_DELAY    = 4'd6,
        IDX_STATUS   = 4'd7,
        IDX_RXSTAT   = 4'd8,
        IDX_TXSTAT   = 4'd9,
        IDX_INT_EN   = 4'd10,
        IDX_INT_PEND = 4'd11
    } reg_idx_e;

    // STATUS / INT_EN / INT_PEND bit positions
    localparam int NUM_ST    = 6;
    localparam int ST_TX_INT = 0;
    localparam int ST_RX_INT = 1;
    localparam int ST_P_ERR  = 2;
    localparam int ST_ST_ERR = 3;
    localparam int ST_TX_OVF = 4;
    localparam int ST_RX_UDF = 5;

    // CONF bit positions
    localparam int CONF_CHECK    = 0;
    localparam int CONF_PARITY   = 1;
    localparam int CONF_STOP_BIT = 2;
    localparam int CONF_ST_CHECK = 3;
    localparam int CONF_TXRST    = 14;
    localparam int CONF_RXRST    = 15;

    // Reset values of the writable configuration registers
    localparam logic [31:0] CONF_RST   = 32'h4;
    localparam logic [31:0] RXTRIG_RST = 32'h1;
    localparam logic [31:0] DELAY_RST  = 32'h2;

    // True for indexes that exist in the register map
    function automatic logic is_mapped(input logic [3:0] idx);
        return idx <= 4'(IDX_INT_PEND);
    endfunction

    // True for registers that reject writes
    function automatic logic is_read_only(input logic [3:0] idx);
        return (idx == IDX_RX) || (idx == IDX_RXSTAT) ||
               (idx == IDX_TXSTAT) || (idx == IDX_INT_PEND);
    endfunction

endpackage

// File: rtl/uart_err_sync.sv
// Brings one RX-domain error level into clk, flags its rising edge, and runs
// the acknowledge handshake back to the RX side once software clears the flag.
module uart_err_sync (
    input  logic clk,
    input  logic rst_,
    input  logic err,
    input  logic clr,
    output logic rise,
    output logic ack
);
    logic sync1;
    logic sync2;
    logic prev;

    // Two-flop synchronizer followed by an edge-history flop
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= err;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

    // Ack rises after a real clear (not one overridden by a new edge) and
    // holds until the synchronized error has gone low
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ack <= 1'b0;
        end else if (clr && !rise) begin
            ack <= 1'b1;
        end else if (ack && !sync2) begin
            ack <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_apb_regs_gen2.sv
// Zero-wait APB slave register file for the UART: configuration registers,
// TX push / RX pop ports onto the FIFOs, sticky W1C status with per-source
// interrupt enables, and PSLVERR for unmapped or read-only-write accesses.
module uart_apb_regs_gen2
    import uart_regs_pkg::*;
#(
    parameter int          DATA_W   = 8,
    parameter int          FIFO_AW  = 4,
    parameter int          BAUD_W   = 16,
    parameter int unsigned BAUD_RST = 'h152,
    parameter int          DELAY_W  = 4
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic [3:0]         paddr_i,
    input  logic [31:0]        pwdata_i,
    input  logic               psel_i,
    input  logic               penable_i,
    input  logic               pwrite_i,
    output logic [31:0]        prdata_o,
    output logic               pready_o,
    output logic               pslverr_o,
    input  logic               st_error,
    input  logic               p_error,
    output logic               st_error_ack,
    output logic               p_error_ack,
    input  logic               rx_fifo_rempty,
    input  logic [FIFO_AW:0]   rx_fifo_cnt,
    input  logic [DATA_W-1:0]  rx_data,
    output logic               rx_fifo_rinc,
    input  logic               tx_fifo_wfull,
    input  logic [FIFO_AW:0]   tx_fifo_cnt,
    output logic [DATA_W-1:0]  tx_data,
    output logic               tx_fifo_winc,
    output logic [BAUD_W-1:0]  baud_div,
    output logic               check,
    output logic               parity,
    output logic               stop_bit,
    output logic               st_check,
    output logic               rxrst,
    output logic               txrst,
    output logic [DELAY_W-1:0] two_tx_delay,
    output logic               uart_int_o
);
    localparam int CNT_W = FIFO_AW + 1;

    logic              setup;
    logic              access;
    logic              bad_access;
    logic              wr_en;
    logic              rd_setup;
    logic              tx_push;
    logic              rx_pop_req;
    logic [CNT_W-1:0]  rx_trig;
    logic [CNT_W-1:0]  tx_trig;
    logic [NUM_ST-1:0] status;
    logic [NUM_ST-1:0] int_en;
    logic [NUM_ST-1:0] status_set;
    logic [NUM_ST-1:0] status_clr;
    logic              rx_cond;
    logic              tx_cond;
    logic              rx_cond_q;
    logic              tx_cond_q;
    logic              p_rise;
    logic              st_rise;
    logic [31:0]       rdata;
    logic              unused_pwdata;

    assign pready_o      = 1'b1;
    assign unused_pwdata = ^pwdata_i;

    assign setup      = psel_i & ~penable_i;
    assign access     = psel_i & penable_i;
    assign bad_access = !is_mapped(paddr_i) || (pwrite_i && is_read_only(paddr_i));
    assign wr_en      = access & pwrite_i & ~bad_access;
    assign rd_setup   = setup & ~pwrite_i;
    assign tx_push    = wr_en && (paddr_i == IDX_TX);
    assign rx_pop_req = rd_setup && (paddr_i == IDX_RX);

    // Configuration registers; the flops themselves drive the config outputs
    // NOTE: state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            baud_div     <= BAUD_W'(BAUD_RST);
            check        <= CONF_RST[CONF_CHECK];
            parity       <= CONF_RST[CONF_PARITY];
            stop_bit     <= CONF_RST[CONF_STOP_BIT];
            st_check     <= CONF_RST[CONF_ST_CHECK];
            txrst        <= CONF_RST[CONF_TXRST];
            rxrst        <= CONF_RST[CONF_RXRST];
            rx_trig      <= CNT_W'(RXTRIG_RST);
            tx_trig      <= '0;
            two_tx_delay <= DELAY_W'(DELAY_RST);
            int_en       <= '0;
        end else if (wr_en) begin
            case (paddr_i)
                IDX_BAUD:   baud_div <= pwdata_i[BAUD_W-1:0];
                IDX_CONF: begin
                    check    <= pwdata_i[CONF_CHECK];
                    parity   <= pwdata_i[CONF_PARITY];
                    stop_bit <= pwdata_i[CONF_STOP_BIT];
                    st_check <= pwdata_i[CONF_ST_CHECK];
                    txrst    <= pwdata_i[CONF_TXRST];
                    rxrst    <= pwdata_i[CONF_RXRST];
                end
                IDX_RXTRIG: rx_trig      <= pwdata_i[CNT_W-1:0];
                IDX_TXTRIG: tx_trig      <= pwdata_i[CNT_W-1:0];
                IDX_DELAY:  two_tx_delay <= pwdata_i[DELAY_W-1:0];
                IDX_INT_EN: int_en       <= pwdata_i[NUM_ST-1:0];
                default:    ;
            endcase
        end
    end

    // TX push and RX pop strobes, one cycle after the triggering access
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            tx_data      <= '0;
            tx_fifo_winc <= 1'b0;
            rx_fifo_rinc <= 1'b0;
        end else begin
            tx_fifo_winc <= tx_push & ~tx_fifo_wfull & ~txrst;
            rx_fifo_rinc <= rx_pop_req & ~rx_fifo_rempty;
            if (tx_push) begin
                tx_data <= pwdata_i[DATA_W-1:0];
            end
        end
    end

    // Read mux, evaluated during the setup phase
    // NOTE: assigning a default first keeps this block free of latches.
    always_comb begin
        rdata = '0;
        case (paddr_i)
            IDX_TX:       rdata = 32'(tx_data);
            IDX_RX:       rdata = rx_fifo_rempty ? 32'h0 : 32'(rx_data);
            IDX_BAUD:     rdata = 32'(baud_div);
            IDX_CONF: begin
                rdata[CONF_CHECK]    = check;
                rdata[CONF_PARITY]   = parity;
                rdata[CONF_STOP_BIT] = stop_bit;
                rdata[CONF_ST_CHECK] = st_check;
                rdata[CONF_TXRST]    = txrst;
                rdata[CONF_RXRST]    = rxrst;
            end
            IDX_RXTRIG:   rdata = 32'(rx_trig);
            IDX_TXTRIG:   rdata = 32'(tx_trig);
            IDX_DELAY:    rdata = 32'(two_tx_delay);
            IDX_STATUS:   rdata = 32'(status);
            IDX_RXSTAT:   rdata = 32'(rx_fifo_cnt);
            IDX_TXSTAT:   rdata = 32'(tx_fifo_cnt);
            IDX_INT_EN:   rdata = 32'(int_en);
            IDX_INT_PEND: rdata = 32'(status & int_en);
            default:      rdata = '0;
        endcase
    end

    // APB response: data and error captured at setup, presented in access
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            prdata_o  <= '0;
            pslverr_o <= 1'b0;
        end else begin
            pslverr_o <= setup & bad_access;
            if (rd_setup) begin
                prdata_o <= rdata;
            end
        end
    end

    assign rx_cond = (rx_fifo_cnt >= rx_trig);
    assign tx_cond = (tx_fifo_cnt <= tx_trig);

    // Hardware set sources and software W1C clear mask for STATUS
    always_comb begin
        status_set            = '0;
        status_set[ST_TX_INT] = tx_cond & ~tx_cond_q;
        status_set[ST_RX_INT] = rx_cond & ~rx_cond_q;
        status_set[ST_P_ERR]  = p_rise;
        status_set[ST_ST_ERR] = st_rise;
        status_set[ST_TX_OVF] = tx_push & tx_fifo_wfull;
        status_set[ST_RX_UDF] = rx_pop_req & rx_fifo_rempty;
        status_clr            = '0;
        if (wr_en && (paddr_i == IDX_STATUS)) begin
            status_clr = pwdata_i[NUM_ST-1:0];
        end
    end

    // Sticky STATUS (a set in the same cycle beats a clear), trigger
    // history and the registered interrupt line
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            status     <= '0;
            rx_cond_q  <= 1'b0;
            tx_cond_q  <= 1'b0;
            uart_int_o <= 1'b0;
        end else begin
            status     <= (status & ~status_clr) | status_set;
            rx_cond_q  <= rx_cond;
            tx_cond_q  <= tx_cond;
            uart_int_o <= |(status & int_en);
        end
    end

    uart_err_sync u_p_err_sync (
        .clk  (clk),
        .rst_ (rst_),
        .err  (p_error),
        .clr  (status_clr[ST_P_ERR] & status[ST_P_ERR]),
        .rise (p_rise),
        .ack  (p_error_ack)
    );

    uart_err_sync u_st_err_sync (
        .clk  (clk),
        .rst_ (rst_),
        .err  (st_error),
        .clr  (status_clr[ST_ST_ERR] & status[ST_ST_ERR]),
        .rise (st_rise),
        .ack  (st_error_ack)
    );

endmodule
